// File: rtl/execute_stage_ctrl_if.sv
// Execute-stage bus bundle: decoded D-stage fields, hazard controls,
// the external ALU connection, the M pipeline register and the CC flags.
// "slave" is the execute stage itself; "master" is whatever surrounds it.
interface execute_stage_ctrl_if #(
   parameter int unsigned DATA_W = 64
);
   logic [3:0]        d_icode;
   logic [3:0]        d_ifun;
   logic [DATA_W-1:0] d_valc;
   logic [DATA_W-1:0] d_vala;
   logic [DATA_W-1:0] d_valb;
   logic [3:0]        d_dste;
   logic [3:0]        d_dstm;
   logic [3:0]        d_stat;

   logic              e_stall;
   logic              e_bubble;
   logic              m_bubble;
   logic [3:0]        m_stat_in;
   logic [3:0]        w_stat_in;

   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [1:0]        alu_fun;
   logic [DATA_W-1:0] alu_out;
   logic              alu_zf;
   logic              alu_sf;
   logic              alu_of;

   logic              e_cnd;
   logic [3:0]        e_dste_out;

   logic [3:0]        M_icode;
   logic [3:0]        M_dste;
   logic [3:0]        M_dstm;
   logic [3:0]        M_stat;
   logic              M_cnd;
   logic [DATA_W-1:0] M_vale;
   logic [DATA_W-1:0] M_vala;

   logic              cc_zf;
   logic              cc_sf;
   logic              cc_of;

   modport slave (
      input  d_icode, d_ifun, d_valc, d_vala, d_valb, d_dste, d_dstm, d_stat,
      input  e_stall, e_bubble, m_bubble, m_stat_in, w_stat_in,
      input  alu_out, alu_zf, alu_sf, alu_of,
      output alu_a, alu_b, alu_fun,
      output e_cnd, e_dste_out,
      output M_icode, M_dste, M_dstm, M_stat, M_cnd, M_vale, M_vala,
      output cc_zf, cc_sf, cc_of
   );

   modport master (
      output d_icode, d_ifun, d_valc, d_vala, d_valb, d_dste, d_dstm, d_stat,
      output e_stall, e_bubble, m_bubble, m_stat_in, w_stat_in,
      output alu_out, alu_zf, alu_sf, alu_of,
      input  alu_a, alu_b, alu_fun,
      input  e_cnd, e_dste_out,
      input  M_icode, M_dste, M_dstm, M_stat, M_cnd, M_vale, M_vala,
      input  cc_zf, cc_sf, cc_of
   );
endinterface

// File: rtl/execute_stage_ctrl.sv
// Y86-64 PIPE execute stage controller: E pipeline register, ALU operand
// and function selection, condition-code register, cnd evaluation for
// cmovXX/jXX, and the M pipeline register.
module execute_stage_ctrl #(
   parameter int unsigned DATA_W = 64,
   parameter logic [3:0]  RNONE  = 4'hF,
   parameter logic [2:0]  CC_RST = 3'b100
) (
   input logic                 clk,
   input logic                 rst_n,
   execute_stage_ctrl_if.slave bus
);

   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] STAT_AOK = 4'h1;
   localparam logic [3:0] STAT_HLT = 4'h2;
   localparam logic [3:0] STAT_ADR = 4'h3;
   localparam logic [3:0] STAT_INS = 4'h4;

   localparam logic [DATA_W-1:0] POS8 = DATA_W'(8);
   localparam logic [DATA_W-1:0] NEG8 = ~DATA_W'(8) + DATA_W'(1);

   logic [3:0]        eIcode_q, eIcode_d;
   logic [3:0]        eIfun_q,  eIfun_d;
   logic [DATA_W-1:0] eValc_q,  eValc_d;
   logic [DATA_W-1:0] eVala_q,  eVala_d;
   logic [DATA_W-1:0] eValb_q,  eValb_d;
   logic [3:0]        eDste_q,  eDste_d;
   logic [3:0]        eDstm_q,  eDstm_d;
   logic [3:0]        eStat_q,  eStat_d;

   logic [2:0]        cc_q, cc_d;

   logic [3:0]        mIcode_q, mIcode_d;
   logic              mCnd_q,   mCnd_d;
   logic [DATA_W-1:0] mVale_q,  mVale_d;
   logic [DATA_W-1:0] mVala_q,  mVala_d;
   logic [3:0]        mDste_q,  mDste_d;
   logic [3:0]        mDstm_q,  mDstm_d;
   logic [3:0]        mStat_q,  mStat_d;

   logic [DATA_W-1:0] aluA;
   logic [DATA_W-1:0] aluB;
   logic [1:0]        aluFun;
   logic              cnd;
   logic [3:0]        dsteOut;
   logic              setCc;
   logic              mExc;
   logic              wExc;

   // E register next state: stall holds and wins over bubble, bubble inserts a NOP
   always_comb begin
      eIcode_d = eIcode_q;
      eIfun_d  = eIfun_q;
      eValc_d  = eValc_q;
      eVala_d  = eVala_q;
      eValb_d  = eValb_q;
      eDste_d  = eDste_q;
      eDstm_d  = eDstm_q;
      eStat_d  = eStat_q;
      if (!bus.e_stall) begin
         if (bus.e_bubble) begin
            eIcode_d = I_NOP;
            eIfun_d  = 4'h0;
            eValc_d  = '0;
            eVala_d  = '0;
            eValb_d  = '0;
            eDste_d  = RNONE;
            eDstm_d  = RNONE;
            eStat_d  = STAT_AOK;
         end else begin
            eIcode_d = bus.d_icode;
            eIfun_d  = bus.d_ifun;
            eValc_d  = bus.d_valc;
            eVala_d  = bus.d_vala;
            eValb_d  = bus.d_valb;
            eDste_d  = bus.d_dste;
            eDstm_d  = bus.d_dstm;
            eStat_d  = bus.d_stat;
         end
      end
   end

   // E register, reset to a bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eIcode_q <= I_NOP;
         eIfun_q  <= 4'h0;
         eValc_q  <= '0;
         eVala_q  <= '0;
         eValb_q  <= '0;
         eDste_q  <= RNONE;
         eDstm_q  <= RNONE;
         eStat_q  <= STAT_AOK;
      end else begin
         eIcode_q <= eIcode_d;
         eIfun_q  <= eIfun_d;
         eValc_q  <= eValc_d;
         eVala_q  <= eVala_d;
         eValb_q  <= eValb_d;
         eDste_q  <= eDste_d;
         eDstm_q  <= eDstm_d;
         eStat_q  <= eStat_d;
      end
   end

   // ALU operand and function selection; stack ops adjust valB by +/-8
   always_comb begin
      aluA = '0;
      aluB = '0;
      case (eIcode_q)
         I_RRMOVQ: aluA = eVala_q;
         I_IRMOVQ: aluA = eValc_q;
         I_OPQ: begin
            aluA = eVala_q;
            aluB = eValb_q;
         end
         I_RMMOVQ, I_MRMOVQ: begin
            aluA = eValc_q;
            aluB = eValb_q;
         end
         I_CALL, I_PUSHQ: begin
            aluA = NEG8;
            aluB = eValb_q;
         end
         I_RET, I_POPQ: begin
            aluA = POS8;
            aluB = eValb_q;
         end
         default: ;
      endcase
      aluFun = (eIcode_q == I_OPQ) ? eIfun_q[1:0] : 2'd0;
   end

   // Condition evaluation from the CC register, and cmov destination gating
   always_comb begin
      case (eIfun_q)
         4'h0:    cnd = 1'b1;
         4'h1:    cnd = (cc_q[1] ^ cc_q[0]) | cc_q[2];
         4'h2:    cnd = cc_q[1] ^ cc_q[0];
         4'h3:    cnd = cc_q[2];
         4'h4:    cnd = ~cc_q[2];
         4'h5:    cnd = ~(cc_q[1] ^ cc_q[0]);
         4'h6:    cnd = ~(cc_q[1] ^ cc_q[0]) & ~cc_q[2];
         default: cnd = 1'b0;
      endcase
      dsteOut = ((eIcode_q == I_RRMOVQ) && !cnd) ? RNONE : eDste_q;
   end

   // CC update: only an OPq sets flags, and not while a later stage holds an exception
   always_comb begin
      mExc  = (bus.m_stat_in == STAT_HLT) || (bus.m_stat_in == STAT_ADR) ||
              (bus.m_stat_in == STAT_INS);
      wExc  = (bus.w_stat_in == STAT_HLT) || (bus.w_stat_in == STAT_ADR) ||
              (bus.w_stat_in == STAT_INS);
      setCc = (eIcode_q == I_OPQ) && !mExc && !wExc;
      cc_d  = setCc ? {bus.alu_zf, bus.alu_sf, bus.alu_of} : cc_q;
   end

   // Condition-code register {ZF,SF,OF}
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cc_q <= CC_RST;
      end else begin
         cc_q <= cc_d;
      end
   end

   // M register next state: bubble or capture the executed instruction
   always_comb begin
      if (bus.m_bubble) begin
         mIcode_d = I_NOP;
         mCnd_d   = 1'b0;
         mVale_d  = '0;
         mVala_d  = '0;
         mDste_d  = RNONE;
         mDstm_d  = RNONE;
         mStat_d  = STAT_AOK;
      end else begin
         mIcode_d = eIcode_q;
         mCnd_d   = cnd;
         mVale_d  = bus.alu_out;
         mVala_d  = eVala_q;
         mDste_d  = dsteOut;
         mDstm_d  = eDstm_q;
         mStat_d  = eStat_q;
      end
   end

   // M register, reset to a bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mIcode_q <= I_NOP;
         mCnd_q   <= 1'b0;
         mVale_q  <= '0;
         mVala_q  <= '0;
         mDste_q  <= RNONE;
         mDstm_q  <= RNONE;
         mStat_q  <= STAT_AOK;
      end else begin
         mIcode_q <= mIcode_d;
         mCnd_q   <= mCnd_d;
         mVale_q  <= mVale_d;
         mVala_q  <= mVala_d;
         mDste_q  <= mDste_d;
         mDstm_q  <= mDstm_d;
         mStat_q  <= mStat_d;
      end
   end

   assign bus.alu_a      = aluA;
   assign bus.alu_b      = aluB;
   assign bus.alu_fun    = aluFun;
   assign bus.e_cnd      = cnd;
   assign bus.e_dste_out = dsteOut;
   assign bus.M_icode    = mIcode_q;
   assign bus.M_cnd      = mCnd_q;
   assign bus.M_vale     = mVale_q;
   assign bus.M_vala     = mVala_q;
   assign bus.M_dste     = mDste_q;
   assign bus.M_dstm     = mDstm_q;
   assign bus.M_stat     = mStat_q;
   assign bus.cc_zf      = cc_q[2];
   assign bus.cc_sf      = cc_q[1];
   assign bus.cc_of      = cc_q[0];

endmodule

// File: tb/tb_execute_stage_ctrl.sv
// Self-checking bench for execute_stage_ctrl: directed scenarios followed by
// a randomized run compared against an instruction-level reference model.
module tb_execute_stage_ctrl;

   typedef struct packed {
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [63:0] valc;
      logic [63:0] vala;
      logic [63:0] valb;
      logic [3:0]  dste;
      logic [3:0]  dstm;
      logic [3:0]  stat;
   } eReg_t;

   typedef struct packed {
      logic [3:0]  icode;
      logic        cnd;
      logic [63:0] vale;
      logic [63:0] vala;
      logic [3:0]  dste;
      logic [3:0]  dstm;
      logic [3:0]  stat;
   } mReg_t;

   typedef struct packed {
      logic [63:0] res;
      logic        zf;
      logic        sf;
      logic        of;
   } aluRes_t;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   eReg_t      mE;
   mReg_t      mM;
   logic [2:0] mCc;

   aluRes_t aluNow;

   execute_stage_ctrl_if #(.DATA_W(64)) bus ();

   execute_stage_ctrl #(
      .DATA_W(64),
      .RNONE(4'hF),
      .CC_RST(3'b100)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   // Free-running clock, 10 time units per cycle
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Y86 ALU semantics: result = B op A; OF from two's-complement overflow
   function automatic aluRes_t aluCompute(logic [63:0] a, logic [63:0] b, logic [1:0] fun);
      aluRes_t r;
      r.of = 1'b0;
      case (fun)
         2'd0: begin
            r.res = b + a;
            r.of  = (a[63] == b[63]) && (r.res[63] != a[63]);
         end
         2'd1: begin
            r.res = b - a;
            r.of  = (a[63] != b[63]) && (r.res[63] != b[63]);
         end
         2'd2:    r.res = b & a;
         default: r.res = b ^ a;
      endcase
      r.zf = (r.res == 64'd0);
      r.sf = r.res[63];
      return r;
   endfunction

   // External ALU attached to the DUT operand outputs
   always_comb begin
      aluNow      = aluCompute(bus.alu_a, bus.alu_b, bus.alu_fun);
      bus.alu_out = aluNow.res;
      bus.alu_zf  = aluNow.zf;
      bus.alu_sf  = aluNow.sf;
      bus.alu_of  = aluNow.of;
   end

   // Reference model: what each instruction class feeds the ALU
   function automatic logic [63:0] refAluA(eReg_t e);
      if (e.icode == 4'h2 || e.icode == 4'h6) return e.vala;
      if (e.icode >= 4'h3 && e.icode <= 4'h5) return e.valc;
      if (e.icode == 4'h8 || e.icode == 4'hA) return -64'sd8;
      if (e.icode == 4'h9 || e.icode == 4'hB) return 64'd8;
      return 64'd0;
   endfunction

   function automatic logic [63:0] refAluB(eReg_t e);
      if ((e.icode >= 4'h4 && e.icode <= 4'h6) || (e.icode >= 4'h8 && e.icode <= 4'hB))
         return e.valb;
      return 64'd0;
   endfunction

   function automatic logic [1:0] refAluFun(eReg_t e);
      return (e.icode == 4'h6) ? e.ifun[1:0] : 2'd0;
   endfunction

   // Branch/cmov condition from signed-compare meaning of the flags
   function automatic logic refCnd(logic [3:0] ifun, logic [2:0] cc);
      logic zf, less;
      zf   = cc[2];
      less = cc[1] ^ cc[0];
      case (ifun)
         4'd0:    return 1'b1;
         4'd1:    return less || zf;
         4'd2:    return less;
         4'd3:    return zf;
         4'd4:    return !zf;
         4'd5:    return !less;
         4'd6:    return !less && !zf;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] refDste(eReg_t e, logic [2:0] cc);
      if (e.icode == 4'h2 && !refCnd(e.ifun, cc)) return 4'hF;
      return e.dste;
   endfunction

   function automatic logic isExc(logic [3:0] s);
      return s >= 4'd2 && s <= 4'd4;
   endfunction

   task automatic modelReset();
      mE  = '{icode: 4'h1, ifun: 4'h0, valc: 64'd0, vala: 64'd0, valb: 64'd0,
              dste: 4'hF, dstm: 4'hF, stat: 4'h1};
      mM  = '{icode: 4'h1, cnd: 1'b0, vale: 64'd0, vala: 64'd0,
              dste: 4'hF, dstm: 4'hF, stat: 4'h1};
      mCc = 3'b100;
   endtask

   task automatic applyStimulus(input logic [3:0] icode, input logic [3:0] ifun,
                                input logic [63:0] valc, input logic [63:0] vala,
                                input logic [63:0] valb, input logic [3:0] dste,
                                input logic [3:0] dstm, input logic [3:0] stat);
      bus.d_icode = icode;
      bus.d_ifun  = ifun;
      bus.d_valc  = valc;
      bus.d_vala  = vala;
      bus.d_valb  = valb;
      bus.d_dste  = dste;
      bus.d_dstm  = dstm;
      bus.d_stat  = stat;
   endtask

   task automatic applyNop();
      applyStimulus(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 4'h1);
   endtask

   // One clock edge: advance the reference model, then settle at the negedge
   task automatic cycle();
      eReg_t      nE;
      mReg_t      nM;
      logic [2:0] nCc;
      aluRes_t    r;
      r   = aluCompute(refAluA(mE), refAluB(mE), refAluFun(mE));
      nE  = mE;
      if (!bus.e_stall) begin
         if (bus.e_bubble)
            nE = '{icode: 4'h1, ifun: 4'h0, valc: 64'd0, vala: 64'd0, valb: 64'd0,
                   dste: 4'hF, dstm: 4'hF, stat: 4'h1};
         else
            nE = '{icode: bus.d_icode, ifun: bus.d_ifun, valc: bus.d_valc,
                   vala: bus.d_vala, valb: bus.d_valb, dste: bus.d_dste,
                   dstm: bus.d_dstm, stat: bus.d_stat};
      end
      if (bus.m_bubble)
         nM = '{icode: 4'h1, cnd: 1'b0, vale: 64'd0, vala: 64'd0,
                dste: 4'hF, dstm: 4'hF, stat: 4'h1};
      else
         nM = '{icode: mE.icode, cnd: refCnd(mE.ifun, mCc), vale: r.res, vala: mE.vala,
                dste: refDste(mE, mCc), dstm: mE.dstm, stat: mE.stat};
      nCc = mCc;
      if (mE.icode == 4'h6 && !isExc(bus.m_stat_in) && !isExc(bus.w_stat_in))
         nCc = {r.zf, r.sf, r.of};
      @(posedge clk);
      mE  = nE;
      mM  = nM;
      mCc = nCc;
      @(negedge clk);
   endtask

   // Power-on reset and an asynchronous reset arriving mid-run with addq in E
   task automatic test_reset();
      rst_n = 1'b0;
      modelReset();
      repeat (2) @(negedge clk);
      checks++; if (bus.M_icode !== 4'h1) begin errors++; $display("[TB] FAIL rst_M_icode: got %h expected 1", bus.M_icode); end
      checks++; if (bus.M_dste !== 4'hF) begin errors++; $display("[TB] FAIL rst_M_dste: got %h expected F", bus.M_dste); end
      checks++; if ({bus.cc_zf, bus.cc_sf, bus.cc_of} !== 3'b100) begin errors++; $display("[TB] FAIL rst_cc: got %b expected 100", {bus.cc_zf, bus.cc_sf, bus.cc_of}); end
      rst_n = 1'b1;
      applyStimulus(4'h6, 4'h0, 64'd0, 64'd5, 64'd7, 4'h2, 4'hF, 4'h1);
      cycle();
      cycle();
      checks++; if ({bus.cc_zf, bus.cc_sf, bus.cc_of} !== 3'b000) begin errors++; $display("[TB] FAIL pre_rst_cc: got %b expected 000", {bus.cc_zf, bus.cc_sf, bus.cc_of}); end
      checks++; if (bus.M_vale !== 64'd12) begin errors++; $display("[TB] FAIL pre_rst_M_vale: got %h expected c", bus.M_vale); end
      #2 rst_n = 1'b0;
      modelReset();
      #1;
      checks++; if (bus.M_icode !== 4'h1) begin errors++; $display("[TB] FAIL async_M_icode: got %h expected 1", bus.M_icode); end
      checks++; if (bus.M_vale !== 64'd0) begin errors++; $display("[TB] FAIL async_M_vale: got %h expected 0", bus.M_vale); end
      checks++; if (bus.alu_a !== 64'd0) begin errors++; $display("[TB] FAIL async_alu_a: got %h expected 0", bus.alu_a); end
      checks++; if (bus.e_dste_out !== 4'hF) begin errors++; $display("[TB] FAIL async_e_dste: got %h expected F", bus.e_dste_out); end
      checks++; if ({bus.cc_zf, bus.cc_sf, bus.cc_of} !== 3'b100) begin errors++; $display("[TB] FAIL async_cc: got %b expected 100", {bus.cc_zf, bus.cc_sf, bus.cc_of}); end
      applyNop();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // addq producing zero, then jne and je reading the new flags
   task automatic test_addq();
      applyStimulus(4'h6, 4'h0, 64'd0, 64'd5, -64'sd5, 4'h3, 4'hF, 4'h1);
      cycle();
      checks++; if (bus.alu_fun !== 2'd0) begin errors++; $display("[TB] FAIL addq_alu_fun: got %0d expected 0", bus.alu_fun); end
      checks++; if (bus.alu_a !== 64'd5) begin errors++; $display("[TB] FAIL addq_alu_a: got %h expected 5", bus.alu_a); end
      checks++; if (bus.alu_b !== 64'hFFFF_FFFF_FFFF_FFFB) begin errors++; $display("[TB] FAIL addq_alu_b: got %h expected fffffffffffffffb", bus.alu_b); end
      applyStimulus(4'h7, 4'h4, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF, 4'h1);
      cycle();
      checks++; if ({bus.cc_zf, bus.cc_sf, bus.cc_of} !== 3'b100) begin errors++; $display("[TB] FAIL addq_cc: got %b expected 100", {bus.cc_zf, bus.cc_sf, bus.cc_of}); end
      checks++; if (bus.M_vale !== 64'd0) begin errors++; $display("[TB] FAIL addq_M_vale: got %h expected 0", bus.M_vale); end
      checks++; if (bus.e_cnd !== 1'b0) begin errors++; $display("[TB] FAIL jne_cnd: got %b expected 0", bus.e_cnd); end
      applyStimulus(4'h7, 4'h3, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF, 4'h1);
      cycle();
      checks++; if (bus.e_cnd !== 1'b1) begin errors++; $display("[TB] FAIL je_cnd: got %b expected 1", bus.e_cnd); end
      applyNop();
      cycle();
   endtask

   // subq giving negative result, then cmovl (taken) and cmovge (not taken)
   task automatic test_subq_cmov();
      applyStimulus(4'h6, 4'h1, 64'd0, 64'd1, 64'd0, 4'h6, 4'hF, 4'h1);
      cycle();
      applyStimulus(4'h2, 4'h2, 64'd0, 64'h1234, 64'd0, 4'h3, 4'hF, 4'h1);
      cycle();
      checks++; if ({bus.cc_zf, bus.cc_sf, bus.cc_of} !== 3'b010) begin errors++; $display("[TB] FAIL subq_cc: got %b expected 010", {bus.cc_zf, bus.cc_sf, bus.cc_of}); end
      checks++; if (bus.e_cnd !== 1'b1) begin errors++; $display("[TB] FAIL cmovl_cnd: got %b expected 1", bus.e_cnd); end
      applyNop();
      cycle();
      checks++; if (bus.M_dste !== 4'h3) begin errors++; $display("[TB] FAIL cmovl_M_dste: got %h expected 3", bus.M_dste); end
      checks++; if (bus.M_vale !== 64'h1234) begin errors++; $display("[TB] FAIL cmovl_M_vale: got %h expected 1234", bus.M_vale); end
      applyStimulus(4'h2, 4'h5, 64'd0, 64'h1234, 64'd0, 4'h3, 4'hF, 4'h1);
      cycle();
      checks++; if (bus.e_cnd !== 1'b0) begin errors++; $display("[TB] FAIL cmovge_cnd: got %b expected 0", bus.e_cnd); end
      applyNop();
      cycle();
      checks++; if (bus.M_dste !== 4'hF) begin errors++; $display("[TB] FAIL cmovge_M_dste: got %h expected F", bus.M_dste); end
   endtask

   // An OPq must not update CC while W or M carries an exception status
   task automatic test_exception_gating();
      applyStimulus(4'h6, 4'h0, 64'd0, 64'd1, 64'd1, 4'h4, 4'hF, 4'h1);
      cycle();
      bus.w_stat_in = 4'h3;
      applyNop();
      cycle();
      bus.w_stat_in = 4'h1;
      checks++; if ({bus.cc_zf, bus.cc_sf, bus.cc_of} !== 3'b010) begin errors++; $display("[TB] FAIL wexc_cc: got %b expected 010", {bus.cc_zf, bus.cc_sf, bus.cc_of}); end
      checks++; if (bus.M_icode !== 4'h6) begin errors++; $display("[TB] FAIL wexc_M_icode: got %h expected 6", bus.M_icode); end
      checks++; if (bus.M_vale !== 64'd2) begin errors++; $display("[TB] FAIL wexc_M_vale: got %h expected 2", bus.M_vale); end
      applyStimulus(4'h6, 4'h0, 64'd0, 64'd1, 64'd1, 4'h4, 4'hF, 4'h1);
      cycle();
      bus.m_stat_in = 4'h2;
      applyNop();
      cycle();
      bus.m_stat_in = 4'h1;
      checks++; if ({bus.cc_zf, bus.cc_sf, bus.cc_of} !== 3'b010) begin errors++; $display("[TB] FAIL mexc_cc: got %b expected 010", {bus.cc_zf, bus.cc_sf, bus.cc_of}); end
   endtask

   // Stall priority over bubble, E bubble propagation, M bubble
   task automatic test_hazard();
      applyStimulus(4'h3, 4'h0, 64'h55, 64'd0, 64'd0, 4'h4, 4'hF, 4'h1);
      cycle();
      applyStimulus(4'h2, 4'h0, 64'd0, 64'h99, 64'd0, 4'h7, 4'hF, 4'h1);
      bus.e_stall  = 1'b1;
      bus.e_bubble = 1'b1;
      cycle();
      checks++; if (bus.alu_a !== 64'h55) begin errors++; $display("[TB] FAIL stall_alu_a: got %h expected 55", bus.alu_a); end
      checks++; if (bus.e_dste_out !== 4'h4) begin errors++; $display("[TB] FAIL stall_e_dste: got %h expected 4", bus.e_dste_out); end
      checks++; if (bus.M_vale !== 64'h55) begin errors++; $display("[TB] FAIL stall_M_vale: got %h expected 55", bus.M_vale); end
      bus.e_stall = 1'b0;
      cycle();
      bus.e_bubble = 1'b0;
      checks++; if (bus.alu_a !== 64'd0) begin errors++; $display("[TB] FAIL ebub_alu_a: got %h expected 0", bus.alu_a); end
      checks++; if (bus.M_icode !== 4'h3) begin errors++; $display("[TB] FAIL ebub_M_icode_prev: got %h expected 3", bus.M_icode); end
      applyStimulus(4'h3, 4'h0, 64'h77, 64'd0, 64'd0, 4'h5, 4'h6, 4'h1);
      cycle();
      checks++; if (bus.M_icode !== 4'h1) begin errors++; $display("[TB] FAIL ebub_M_icode: got %h expected 1", bus.M_icode); end
      bus.m_bubble = 1'b1;
      cycle();
      bus.m_bubble = 1'b0;
      checks++; if (bus.M_dste !== 4'hF) begin errors++; $display("[TB] FAIL mbub_M_dste: got %h expected F", bus.M_dste); end
      checks++; if (bus.M_stat !== 4'h1) begin errors++; $display("[TB] FAIL mbub_M_stat: got %h expected 1", bus.M_stat); end
      checks++; if (bus.M_icode !== 4'h1) begin errors++; $display("[TB] FAIL mbub_M_icode: got %h expected 1", bus.M_icode); end
      applyNop();
      cycle();
   endtask

   // Stack pointer adjustment for pushq and ret
   task automatic test_stack();
      applyStimulus(4'hA, 4'h0, 64'd0, 64'hAB, 64'h100, 4'h4, 4'hF, 4'h1);
      cycle();
      checks++; if (bus.alu_a !== 64'hFFFF_FFFF_FFFF_FFF8) begin errors++; $display("[TB] FAIL push_alu_a: got %h expected fffffffffffffff8", bus.alu_a); end
      checks++; if (bus.alu_b !== 64'h100) begin errors++; $display("[TB] FAIL push_alu_b: got %h expected 100", bus.alu_b); end
      applyStimulus(4'h9, 4'h0, 64'd0, 64'd0, 64'hF8, 4'h4, 4'hF, 4'h1);
      cycle();
      checks++; if (bus.M_vale !== 64'hF8) begin errors++; $display("[TB] FAIL push_M_vale: got %h expected f8", bus.M_vale); end
      checks++; if (bus.alu_a !== 64'd8) begin errors++; $display("[TB] FAIL ret_alu_a: got %h expected 8", bus.alu_a); end
      applyNop();
      cycle();
      checks++; if (bus.M_vale !== 64'h100) begin errors++; $display("[TB] FAIL ret_M_vale: got %h expected 100", bus.M_vale); end
      checks++; if (bus.M_icode !== 4'h9) begin errors++; $display("[TB] FAIL ret_M_icode: got %h expected 9", bus.M_icode); end
   endtask

   function automatic logic [63:0] randVal();
      case ($urandom_range(0, 3))
         0:       return 64'($urandom_range(0, 3));
         1:       return {$urandom, $urandom};
         2:       return -64'($urandom_range(0, 3));
         default: return {1'b1, 31'($urandom), 32'($urandom_range(0, 3))};
      endcase
   endfunction

   function automatic logic [3:0] randStat();
      return ($urandom_range(0, 5) == 0) ? 4'($urandom_range(2, 4)) : 4'h1;
   endfunction

   // Randomized instruction stream against the reference model
   task automatic test_random();
      logic [3:0] icode, ifun;
      for (int n = 0; n < 400; n++) begin
         icode = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'($urandom_range(0, 11));
         if (icode == 4'h6)                      ifun = 4'($urandom_range(0, 3));
         else if (icode == 4'h2 || icode == 4'h7) ifun = 4'($urandom_range(0, 9));
         else                                    ifun = 4'h0;
         applyStimulus(icode, ifun, randVal(), randVal(), randVal(),
                       4'($urandom), 4'($urandom), randStat());
         bus.e_stall   = ($urandom_range(0, 7) == 0);
         bus.e_bubble  = ($urandom_range(0, 7) == 0);
         bus.m_bubble  = ($urandom_range(0, 9) == 0);
         bus.m_stat_in = randStat();
         bus.w_stat_in = randStat();
         #1;
         checks++; if (bus.alu_a !== refAluA(mE)) begin errors++; $display("[TB] FAIL rnd_alu_a n=%0d: got %h expected %h", n, bus.alu_a, refAluA(mE)); end
         checks++; if (bus.alu_b !== refAluB(mE)) begin errors++; $display("[TB] FAIL rnd_alu_b n=%0d: got %h expected %h", n, bus.alu_b, refAluB(mE)); end
         checks++; if (bus.alu_fun !== refAluFun(mE)) begin errors++; $display("[TB] FAIL rnd_alu_fun n=%0d: got %0d expected %0d", n, bus.alu_fun, refAluFun(mE)); end
         checks++; if (bus.e_cnd !== refCnd(mE.ifun, mCc)) begin errors++; $display("[TB] FAIL rnd_e_cnd n=%0d: got %b expected %b", n, bus.e_cnd, refCnd(mE.ifun, mCc)); end
         checks++; if (bus.e_dste_out !== refDste(mE, mCc)) begin errors++; $display("[TB] FAIL rnd_e_dste n=%0d: got %h expected %h", n, bus.e_dste_out, refDste(mE, mCc)); end
         cycle();
         checks++; if ({bus.M_icode, bus.M_cnd, bus.M_dste, bus.M_dstm, bus.M_stat} !== {mM.icode, mM.cnd, mM.dste, mM.dstm, mM.stat}) begin errors++; $display("[TB] FAIL rnd_M_ctl n=%0d: got %h/%b/%h/%h/%h expected %h/%b/%h/%h/%h", n, bus.M_icode, bus.M_cnd, bus.M_dste, bus.M_dstm, bus.M_stat, mM.icode, mM.cnd, mM.dste, mM.dstm, mM.stat); end
         checks++; if (bus.M_vale !== mM.vale) begin errors++; $display("[TB] FAIL rnd_M_vale n=%0d: got %h expected %h", n, bus.M_vale, mM.vale); end
         checks++; if (bus.M_vala !== mM.vala) begin errors++; $display("[TB] FAIL rnd_M_vala n=%0d: got %h expected %h", n, bus.M_vala, mM.vala); end
         checks++; if ({bus.cc_zf, bus.cc_sf, bus.cc_of} !== mCc) begin errors++; $display("[TB] FAIL rnd_cc n=%0d: got %b expected %b", n, {bus.cc_zf, bus.cc_sf, bus.cc_of}, mCc); end
      end
   endtask

   // Test sequence
   initial begin
      errors        = 0;
      checks        = 0;
      rst_n         = 1'b0;
      bus.e_stall   = 1'b0;
      bus.e_bubble  = 1'b0;
      bus.m_bubble  = 1'b0;
      bus.m_stat_in = 4'h1;
      bus.w_stat_in = 4'h1;
      applyNop();
      test_reset();
      test_addq();
      test_subq_cmov();
      test_exception_gating();
      test_hazard();
      test_stack();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
